// File: rtl/led_stripe_rx_pkg.sv
// Shared definitions for the LED stripe one-wire receiver and its transmitter.
// Holds the receiver FSM states, word geometry and default bit timing at 100 MHz.
// No logic; helper function only.
package led_stripe_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,  // waiting for the first reset gap
        ST_IDLE = 2'd1,  // frame boundary seen, line low
        ST_HIGH = 2'd2,  // measuring a high pulse
        ST_LOW  = 2'd3   // between bits, watching for the reset gap
    } state_e;

    // One LED word: G, R, B bytes, MSB first on the wire
    localparam int BITS_PER_LED = 24;

    // Default timing shared with the transmitter (clocks at 100 MHz)
    localparam int T0H_CYC          = 40;
    localparam int T1H_CYC          = 80;
    localparam int THRESH_CYC_DEF   = 60;
    localparam int MIN_HIGH_CYC_DEF = 10;
    localparam int MAX_HIGH_CYC_DEF = 200;
    localparam int RESET_CYC_DEF    = 5000;

    // Increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/led_stripe_rx_sync_edge_detect.sv
// Two-flop synchronizer for the stripe data line plus rise/fall edge pulses.
// Latency: level_o lags the pin by 2 clocks; edge pulses are combinational on level_o.
// No backpressure: free-running input path.
module sync_edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Metastability filter followed by a one-cycle history of the clean level
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign level_o = sync2_q;
    assign rise_o  = sync2_q & ~prev_q;
    assign fall_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/led_stripe_rx.sv
// Addressable-LED stripe receiver: pulse-width bit decode into 24-bit GRB words, reset-gap framing.
// Latency: a pin change sampled on edge N produces its output pulse after edge N+2.
// No backpressure: outputs are one-cycle pulses that the consumer must take when offered.
module led_stripe_rx
    import led_stripe_pkg::*;
#(
    parameter int THRESH_CYC   = THRESH_CYC_DEF,
    parameter int MIN_HIGH_CYC = MIN_HIGH_CYC_DEF,
    parameter int MAX_HIGH_CYC = MAX_HIGH_CYC_DEF,
    parameter int RESET_CYC    = RESET_CYC_DEF,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    din,
    output logic [BITS_PER_LED-1:0] word_data,
    output logic                    word_valid,
    output logic [7:0]              word_count,
    output logic                    frame_done,
    output logic                    frame_partial,
    output logic                    bit_error,
    output logic                    synced
);

    localparam logic [CNT_W-1:0] THRESH_L = CNT_W'(THRESH_CYC);
    localparam logic [CNT_W-1:0] MIN_L    = CNT_W'(MIN_HIGH_CYC);
    localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_HIGH_CYC);
    localparam logic [CNT_W-1:0] RESET_L  = CNT_W'(RESET_CYC);
    localparam logic [4:0]       LAST_BIT = 5'(BITS_PER_LED - 1);

    logic line_lvl;
    logic line_rise;
    logic line_fall;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .async_i (din),
        .level_o (line_lvl),
        .rise_o  (line_rise),
        .fall_o  (line_fall)
    );

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic [BITS_PER_LED-1:0] shift_q;
    logic [BITS_PER_LED-1:0] shift_d;
    logic [4:0]              bit_cnt_q;
    logic                    active_q;
    logic                    bit_val;

    logic [BITS_PER_LED-1:0] word_data_q;
    logic                    word_valid_q;
    logic [7:0]              word_count_q;
    logic                    frame_done_q;
    logic                    frame_partial_q;
    logic                    bit_error_q;
    logic                    synced_q;

    // Duration of the current level including this cycle; restarts at 1 on any edge.
    // On a falling edge cnt_q still holds the full high-pulse length.
    always_comb begin
        cnt_d = cnt_q;
        if (line_rise || line_fall) begin
            cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Decoded bit and the shift register with that bit appended at the LSB
    always_comb begin
        bit_val = (cnt_q >= THRESH_L);
        shift_d = {shift_q[BITS_PER_LED-2:0], bit_val};
    end

    // Receiver FSM with registered outputs; event pulses default low every cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_SYNC;
            cnt_q           <= '0;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            active_q        <= 1'b0;
            word_data_q     <= '0;
            word_valid_q    <= 1'b0;
            word_count_q    <= '0;
            frame_done_q    <= 1'b0;
            frame_partial_q <= 1'b0;
            bit_error_q     <= 1'b0;
            synced_q        <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            word_valid_q    <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_partial_q <= 1'b0;
            bit_error_q     <= 1'b0;

            case (state_q)
                // Everything on the line is ignored until a full reset gap
                ST_SYNC: begin
                    if (!line_lvl && (cnt_d >= RESET_L)) begin
                        synced_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (line_rise) begin
                        state_q <= ST_HIGH;
                    end
                end

                ST_HIGH: begin
                    if (line_fall) begin
                        if (cnt_q < MIN_L) begin
                            // Glitch: flagged, bit not counted
                            bit_error_q <= 1'b1;
                        end else begin
                            active_q <= 1'b1;
                            shift_q  <= shift_d;
                            if (bit_cnt_q == LAST_BIT) begin
                                word_data_q  <= shift_d;
                                word_valid_q <= 1'b1;
                                bit_cnt_q    <= '0;
                                word_count_q <= sat_inc8(word_count_q);
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                        state_q <= ST_LOW;
                    end else if (cnt_d >= MAX_L) begin
                        // Stuck-high line: abandon the frame and resynchronise
                        bit_error_q  <= 1'b1;
                        shift_q      <= '0;
                        bit_cnt_q    <= '0;
                        word_count_q <= '0;
                        active_q     <= 1'b0;
                        synced_q     <= 1'b0;
                        state_q      <= ST_SYNC;
                    end
                end

                ST_LOW: begin
                    if (line_rise) begin
                        state_q <= ST_HIGH;
                    end else if (cnt_d >= RESET_L) begin
                        // Frame boundary; leftover partial bits are dropped
                        frame_done_q    <= active_q;
                        frame_partial_q <= active_q && (bit_cnt_q != 5'd0);
                        shift_q         <= '0;
                        bit_cnt_q       <= '0;
                        word_count_q    <= '0;
                        active_q        <= 1'b0;
                        state_q         <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

    assign word_data     = word_data_q;
    assign word_valid    = word_valid_q;
    assign word_count    = word_count_q;
    assign frame_done    = frame_done_q;
    assign frame_partial = frame_partial_q;
    assign bit_error     = bit_error_q;
    assign synced        = synced_q;

endmodule

// File: tb/tb_led_stripe_rx.sv
// Directed testbench for led_stripe_rx: framing, thresholds, errors and resets.
// Inputs change 1 ns after a rising edge; outputs are sampled there or at the falling edge.
// Pulse outputs are tallied by a monitor so long sequences can be checked by count.
module tb_led_stripe_rx;

    logic        clk;
    logic        rstn;
    logic        din;
    logic [23:0] word_data;
    logic        word_valid;
    logic [7:0]  word_count;
    logic        frame_done;
    logic        frame_partial;
    logic        bit_error;
    logic        synced;

    int vectors = 0;
    int errors  = 0;

    int          n_wv = 0;
    int          n_fd = 0;
    int          n_be = 0;
    logic [23:0] last_word = '0;
    logic        last_partial = 1'b0;

    led_stripe_rx dut (
        .clk           (clk),
        .rstn          (rstn),
        .din           (din),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_count    (word_count),
        .frame_done    (frame_done),
        .frame_partial (frame_partial),
        .bit_error     (bit_error),
        .synced        (synced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally one-cycle pulses and capture the values that accompany them
    always @(negedge clk) begin
        if (word_valid) begin
            n_wv++;
            last_word = word_data;
        end
        if (frame_done) begin
            n_fd++;
            last_partial = frame_partial;
        end
        if (bit_error) n_be++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1;
        tick(hi);
        din = 1'b0;
        tick(lo);
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(80, 45);
        else   pulse(40, 85);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        din  = 1'b0;
        #3;
        vectors++;
        if ({word_data, word_valid, word_count, frame_done, frame_partial, bit_error, synced} !== 37'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {word_data, word_valid, word_count, frame_done, frame_partial, bit_error, synced});
        end
        tick(3);
        rstn = 1'b1;
        tick(2);
        vectors++;
        if (synced !== 1'b0) begin
            errors++;
            $display("FAIL reset_synced: got %b, want 0", synced);
        end
    endtask

    task automatic test_basic_frame;
        int wv0, fd0;
        tick(5010);
        vectors++;
        if (synced !== 1'b1) begin
            errors++;
            $display("FAIL basic_synced: got %b, want 1", synced);
        end
        vectors++;
        if (n_fd !== 0) begin
            errors++;
            $display("FAIL basic_no_fd_on_empty_gap: got %0d, want 0", n_fd);
        end
        wv0 = n_wv;
        fd0 = n_fd;
        for (int i = 23; i >= 1; i--) send_bit(logic'((24'hA5C3F0 >> i) & 24'd1));
        // last bit is 0: 40 high, then check exact output latency of word_valid
        din = 1'b1;
        tick(40);
        din = 1'b0;
        tick(2);
        vectors++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_wv_early: got %b, want 0", word_valid);
        end
        tick(1);
        vectors++;
        if (word_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_wv_latency: got %b, want 1", word_valid);
        end
        vectors++;
        if (word_data !== 24'hA5C3F0) begin
            errors++;
            $display("FAIL basic_word: got %h, want a5c3f0", word_data);
        end
        tick(1);
        vectors++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_wv_width: got %b, want 0", word_valid);
        end
        tick(80);
        vectors++;
        if (word_count !== 8'd1) begin
            errors++;
            $display("FAIL basic_word_count: got %0d, want 1", word_count);
        end
        tick(5010);
        vectors++;
        if ((n_fd - fd0) !== 1 || last_partial !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame_done: got %0d partial %b, want 1 partial 0", n_fd - fd0, last_partial);
        end
        vectors++;
        if ((n_wv - wv0) !== 1 || word_count !== 8'd0 || word_data !== 24'hA5C3F0) begin
            errors++;
            $display("FAIL basic_after_gap: got wv %0d cnt %0d data %h, want 1 0 a5c3f0",
                     n_wv - wv0, word_count, word_data);
        end
    endtask

    task automatic test_unsynced;
        int wv0, fd0, be0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        wv0 = n_wv;
        fd0 = n_fd;
        be0 = n_be;
        send_word(24'h5A5A5A);
        pulse(5, 40);
        vectors++;
        if ((n_wv - wv0) !== 0 || (n_be - be0) !== 0) begin
            errors++;
            $display("FAIL unsynced_ignored: got wv %0d be %0d, want 0 0", n_wv - wv0, n_be - be0);
        end
        vectors++;
        if (synced !== 1'b0) begin
            errors++;
            $display("FAIL unsynced_synced_low: got %b, want 0", synced);
        end
        tick(5010);
        vectors++;
        if (synced !== 1'b1 || (n_fd - fd0) !== 0) begin
            errors++;
            $display("FAIL unsynced_first_gap: got synced %b fd %0d, want 1 0", synced, n_fd - fd0);
        end
    endtask

    task automatic test_threshold;
        int wv0, be0;
        logic [20:0] tail;
        tail = 21'h0F0F0F;
        wv0 = n_wv;
        be0 = n_be;
        pulse(59, 60);
        pulse(60, 60);
        pulse(10, 60);
        pulse(9, 60);
        vectors++;
        if ((n_be - be0) !== 1) begin
            errors++;
            $display("FAIL thresh_glitch_error: got %0d, want 1", n_be - be0);
        end
        for (int i = 20; i >= 0; i--) send_bit(tail[i]);
        vectors++;
        if ((n_wv - wv0) !== 1 || last_word !== 24'h4F0F0F) begin
            errors++;
            $display("FAIL thresh_word: got wv %0d data %h, want 1 4f0f0f", n_wv - wv0, last_word);
        end
        tick(5010);
    endtask

    task automatic test_stuck_high;
        int wv0, fd0, be0;
        wv0 = n_wv;
        fd0 = n_fd;
        be0 = n_be;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        pulse(200, 10);
        vectors++;
        if ((n_be - be0) !== 1 || synced !== 1'b0) begin
            errors++;
            $display("FAIL stuck_error: got be %0d synced %b, want 1 0", n_be - be0, synced);
        end
        send_word(24'hFFFFFF);
        vectors++;
        if ((n_wv - wv0) !== 0 || synced !== 1'b0) begin
            errors++;
            $display("FAIL stuck_ignored: got wv %0d synced %b, want 0 0", n_wv - wv0, synced);
        end
        tick(5010);
        vectors++;
        if ((n_fd - fd0) !== 0 || synced !== 1'b1) begin
            errors++;
            $display("FAIL stuck_no_frame_done: got fd %0d synced %b, want 0 1", n_fd - fd0, synced);
        end
    endtask

    task automatic test_partial_frame;
        int wv0, fd0;
        logic [5:0] extra;
        extra = 6'b101101;
        wv0 = n_wv;
        fd0 = n_fd;
        send_word(24'h123456);
        for (int i = 5; i >= 0; i--) send_bit(extra[i]);
        vectors++;
        if ((n_wv - wv0) !== 1 || last_word !== 24'h123456 || word_count !== 8'd1) begin
            errors++;
            $display("FAIL partial_word: got wv %0d data %h cnt %0d, want 1 123456 1",
                     n_wv - wv0, last_word, word_count);
        end
        tick(5010);
        vectors++;
        if ((n_fd - fd0) !== 1 || last_partial !== 1'b1 || word_count !== 8'd0) begin
            errors++;
            $display("FAIL partial_frame_done: got fd %0d partial %b cnt %0d, want 1 1 0",
                     n_fd - fd0, last_partial, word_count);
        end
        vectors++;
        if ((n_wv - wv0) !== 1 || word_data !== 24'h123456) begin
            errors++;
            $display("FAIL partial_no_residue_out: got wv %0d data %h, want 1 123456", n_wv - wv0, word_data);
        end
    endtask

    task automatic test_reset_mid;
        int wv0, fd0;
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        rstn = 1'b0;
        #1;
        vectors++;
        if ({word_data, word_valid, word_count, frame_done, frame_partial, bit_error, synced} !== 37'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h, want 0",
                     {word_data, word_valid, word_count, frame_done, frame_partial, bit_error, synced});
        end
        tick(3);
        rstn = 1'b1;
        wv0 = n_wv;
        fd0 = n_fd;
        tick(5010);
        send_word(24'h3C5A96);
        vectors++;
        if ((n_wv - wv0) !== 1 || last_word !== 24'h3C5A96) begin
            errors++;
            $display("FAIL midreset_word: got wv %0d data %h, want 1 3c5a96", n_wv - wv0, last_word);
        end
        tick(5010);
        vectors++;
        if ((n_fd - fd0) !== 1 || last_partial !== 1'b0) begin
            errors++;
            $display("FAIL midreset_frame: got fd %0d partial %b, want 1 0", n_fd - fd0, last_partial);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_unsynced();
        test_threshold();
        test_stuck_high();
        test_partial_frame();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
